// File: rtl/cache_tag_ctrl_if.sv
// Request, response, tag RAM and fill-port signals of the cache tag controller.
// slave is the controller's view; master is the view of whatever surrounds it.
interface cache_tag_ctrl_if #(
  parameter int AWIDTH = 3,
  parameter int TAG_W  = 13
);
  localparam int DWIDTH = TAG_W + 1;
  localparam int ADDR_W = TAG_W + AWIDTH;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;

  logic              rsp_valid;
  logic              rsp_hit;
  logic [AWIDTH-1:0] rsp_index;

  logic [AWIDTH-1:0] tag_addr;
  logic [DWIDTH-1:0] tag_din;
  logic              tag_we;
  logic [DWIDTH-1:0] tag_dout;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_addr, tag_dout, mem_ack,
    output req_ready, rsp_valid, rsp_hit, rsp_index,
           tag_addr, tag_din, tag_we, mem_req, mem_addr
  );

  modport master (
    output req_valid, req_addr, tag_dout, mem_ack,
    input  req_ready, rsp_valid, rsp_hit, rsp_index,
           tag_addr, tag_din, tag_we, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Direct-mapped cache tag lookup/fill controller; hit responds 2 cycles after accept, miss 4 + ack wait.
// One request in flight: req_ready drops on accept and returns the cycle after the response pulse.
module cache_tag_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TAG_W  = 13
) (
  input  logic             clock,
  input  logic             reset,
  cache_tag_ctrl_if.slave  bus
);
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int DWIDTH = TAG_W + 1;
  localparam int ADDR_W = TAG_W + AWIDTH;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_FILL,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [AWIDTH-1:0] idx;
  } req_t;

  state_t            state_q,     state_d;
  logic [AWIDTH-1:0] cnt_q,       cnt_d;
  req_t              req_q,       req_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q,   rsp_hit_d;
  logic [AWIDTH-1:0] rsp_index_q, rsp_index_d;
  logic              mem_req_q,   mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;

  logic              lookup_hit;

  assign lookup_hit = bus.tag_dout[TAG_W] && (bus.tag_dout[TAG_W-1:0] == req_q.tag);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = rsp_hit_q;
    rsp_index_d = rsp_index_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AWIDTH'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          req_d       = bus.req_addr;
          req_ready_d = 1'b0;
          state_d     = ST_LOOKUP;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          rsp_hit_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = req_q;
          state_d    = ST_MISS;
        end
      end
      ST_MISS: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        rsp_hit_d = 1'b0;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_index_d = req_q.idx;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // RAM controls stay combinational so the RAM samples them on the same edge the FSM advances.
  always_comb begin
    bus.tag_we   = 1'b0;
    bus.tag_din  = '0;
    bus.tag_addr = req_q.idx;
    case (state_q)
      ST_INIT: begin
        bus.tag_we   = 1'b1;
        bus.tag_addr = cnt_q;
      end
      ST_IDLE: begin
        bus.tag_addr = bus.req_addr[AWIDTH-1:0];
      end
      ST_FILL: begin
        bus.tag_we  = 1'b1;
        bus.tag_din = {1'b1, req_q.tag};
      end
      default: begin
        bus.tag_addr = req_q.idx;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_index = rsp_index_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl: behavioural tag RAM, cache-state reference model, directed and random traffic.
module tb_cache_tag_ctrl;
  localparam int AWIDTH = 3;
  localparam int TAG_W  = 13;
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int DWIDTH = TAG_W + 1;
  localparam int ADDR_W = TAG_W + AWIDTH;

  logic clock;
  logic reset;
  logic ram_scramble;
  int   n_checks;
  int   n_fail;

  logic [DWIDTH-1:0] ram [DEPTH];

  // Reference model: which tag each line holds, if any.
  bit [TAG_W-1:0] m_tag [DEPTH];
  bit             m_vld [DEPTH];

  cache_tag_ctrl_if #(.AWIDTH(AWIDTH), .TAG_W(TAG_W)) bus ();

  cache_tag_ctrl #(.AWIDTH(AWIDTH), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (ram_scramble) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DWIDTH'($urandom);
    end else if (bus.tag_we) begin
      ram[bus.tag_addr] <= bus.tag_din;
    end
    bus.tag_dout <= ram[bus.tag_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_tag[i] = '0;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_hit",   32'(bus.rsp_hit),   32'd0);
    check("rst_rsp_index", 32'(bus.rsp_index), 32'd0);
    check("rst_mem_req",   32'(bus.mem_req),   32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
  endtask

  // Called in the first cycle after reset is released.
  task automatic init_seq(input int ack_at);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == ack_at) bus.mem_ack = 1'b1;
      check("init_we",    32'(bus.tag_we),    32'd1);
      check("init_addr",  32'(bus.tag_addr),  32'(k));
      check("init_din",   32'(bus.tag_din),   32'd0);
      check("init_ready", 32'(bus.req_ready), 32'd0);
      tick();
      bus.mem_ack = 1'b0;
    end
    check("init_end_ready", 32'(bus.req_ready), 32'd0);
    check("init_end_we",    32'(bus.tag_we),    32'd0);
    check("init_end_mreq",  32'(bus.mem_req),   32'd0);
    for (int i = 0; i < DEPTH; i++) check("init_ram_clear", 32'(ram[i]), 32'd0);
    tick();
    check("init_ready_rise", 32'(bus.req_ready), 32'd1);
    model_clear();
  endtask

  task automatic do_req(input logic [ADDR_W-1:0] addr, input int dly, input bit stray);
    logic [AWIDTH-1:0] idx;
    logic [TAG_W-1:0]  tg;
    bit  exp_hit;
    int  exp_lat;
    int  budget;
    int  c;
    int  seen_mem;
    int  fills;
    bit  got;
    idx = addr[AWIDTH-1:0];
    tg  = addr[ADDR_W-1:AWIDTH];

    budget = 0;
    while (!bus.req_ready && budget < 20) begin
      if (stray && $urandom_range(0, 2) == 0) bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      budget++;
    end
    check("ready_timeout", 32'(budget < 20), 32'd1);

    exp_hit = m_vld[idx] && (m_tag[idx] == tg);
    exp_lat = exp_hit ? 2 : 4 + dly;

    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = ADDR_W'($urandom);
    check("ready_drop", 32'(bus.req_ready), 32'd0);

    c = 0; seen_mem = 0; fills = 0; got = 1'b0;
    while (!got && c <= 40) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (seen_mem == 0) check("mem_addr", 32'(bus.mem_addr), 32'(addr));
        seen_mem++;
        if (seen_mem == dly + 1) bus.mem_ack = 1'b1;
      end
      if (bus.tag_we) begin
        fills++;
        check("fill_addr", 32'(bus.tag_addr), 32'(idx));
        check("fill_din",  32'(bus.tag_din),  32'({1'b1, tg}));
      end else if (bus.tag_din !== '0) begin
        check("idle_din", 32'(bus.tag_din), 32'd0);
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        check("rsp_latency", 32'(c),             32'(exp_lat));
        check("rsp_hit",     32'(bus.rsp_hit),   32'(exp_hit));
        check("rsp_index",   32'(bus.rsp_index), 32'(idx));
      end else begin
        tick();
        c++;
      end
    end
    bus.mem_ack = 1'b0;
    check("rsp_seen",   32'(got),      32'd1);
    check("fill_count", 32'(fills),    32'(exp_hit ? 0 : 1));
    check("mreq_cycles", 32'(seen_mem), 32'(exp_hit ? 0 : dly + 1));
    tick();
    check("rsp_pulse_end", 32'(bus.rsp_valid), 32'd0);
    check("ready_back",    32'(bus.req_ready), 32'd1);

    if (!exp_hit) begin
      m_vld[idx] = 1'b1;
      m_tag[idx] = tg;
    end
  endtask

  // Hold req_valid across several transactions; each response must pair with exactly one accept.
  task automatic held_test(input logic [ADDR_W-1:0] addr);
    logic [AWIDTH-1:0] idx;
    logic [TAG_W-1:0]  tg;
    int accepts;
    int resps;
    int c;
    bit exp_hit;
    idx = addr[AWIDTH-1:0];
    tg  = addr[ADDR_W-1:AWIDTH];
    accepts = 0; resps = 0; c = 0; exp_hit = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    while (resps < 3 && c < 80) begin
      bus.mem_ack = bus.mem_req;
      if (bus.rsp_valid) begin
        resps++;
        check("held_hit",  32'(bus.rsp_hit), 32'(exp_hit));
        check("held_pair", 32'(accepts),     32'(resps));
        if (resps == 3) bus.req_valid = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) begin
        accepts++;
        exp_hit = m_vld[idx] && (m_tag[idx] == tg);
        m_vld[idx] = 1'b1;
        m_tag[idx] = tg;
      end
      tick();
      c++;
    end
    bus.mem_ack = 1'b0;
    check("held_resps", 32'(resps), 32'd3);
    for (int i = 0; i < 6; i++) begin
      check("held_quiet", 32'(bus.rsp_valid || bus.mem_req), 32'd0);
      tick();
    end
    check("held_accepts", 32'(accepts), 32'd3);
  endtask

  task automatic stray_ack_idle();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stray_ready", 32'(bus.req_ready), 32'd1);
      check("stray_mreq",  32'(bus.mem_req),   32'd0);
      check("stray_rsp",   32'(bus.rsp_valid), 32'd0);
      check("stray_we",    32'(bus.tag_we),    32'd0);
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.mem_ack   = 1'b0;
    model_clear();

    reset = 1'b1;
    ram_scramble = 1'b1;
    tick();
    ram_scramble = 1'b0;
    check_reset_vals();
    reset = 1'b0;
    init_seq(-1);

    do_req(16'h0005, 3, 1'b0);
    do_req(16'h0005, 0, 1'b0);
    do_req(16'h000D, 1, 1'b0);
    do_req(16'h0005, 2, 1'b0);
    do_req(16'h000D, 0, 1'b0);

    // Reset while a fill is outstanding.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0013;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("abort_mreq_up",  32'(bus.mem_req),  32'd1);
    check("abort_mem_addr", 32'(bus.mem_addr), 32'h0013);
    tick();
    reset = 1'b1;
    ram_scramble = 1'b1;
    tick();
    ram_scramble = 1'b0;
    check_reset_vals();
    reset = 1'b0;
    init_seq(3);
    stray_ack_idle();
    do_req(16'h0013, 1, 1'b0);
    do_req(16'h0005, 0, 1'b0);

    held_test(16'h0036);
    stray_ack_idle();

    for (int n = 0; n < 150; n++) begin
      logic [ADDR_W-1:0] a;
      a = {TAG_W'($urandom_range(0, 3)), AWIDTH'($urandom_range(0, DEPTH - 1))};
      do_req(a, $urandom_range(0, 4), 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        if ($urandom_range(0, 1) == 1) bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("gap_quiet", 32'(bus.mem_req || bus.rsp_valid), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
